public_key_row_cache: RTL and testbench

//  Parametrised public-key (A|b) row store for the LWE/Kyber encryption datapath.

---
 rtl/public_key_row_cache.sv | 140 ++++++++++++++
 tb/tb_public_key_row_cache.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/public_key_row_cache.sv
// Public-key (A|b) row store: loads NUM_ROWS rows plus per-row sums, then replays
// them any number of times with columns at or above the latched k masked to zero.
module public_key_row_cache #(
    parameter int  DATA_WIDTH = 16,
    parameter int  NUM_ROWS   = 8,
    parameter int  MAX_COLS   = 4,
    parameter int  SUM_WIDTH  = 16,
    localparam int AW         = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1,
    localparam int KW         = $clog2(MAX_COLS + 1),
    localparam int RW         = MAX_COLS * DATA_WIDTH
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_clear,
    input  logic [KW-1:0]        i_k_cols,
    input  logic                 i_wr_valid,
    output logic                 o_wr_ready,
    input  logic [RW-1:0]        i_wr_row,
    input  logic [SUM_WIDTH-1:0] i_wr_sum,
    input  logic                 i_rd_start,
    output logic                 o_rd_valid,
    input  logic                 i_rd_ready,
    output logic [RW-1:0]        o_rd_row,
    output logic [SUM_WIDTH-1:0] o_rd_sum,
    output logic                 o_rd_last,
    output logic                 o_cache_full,
    output logic                 o_err_k,
    output logic [7:0]           o_pass_count,
    output logic [1:0]           o_state
);

    // Handshakes: a transfer happens on a cycle where valid and ready are both high;
    // the producer holds its payload stable while valid is high and ready is low.

    typedef enum logic [1:0] {
        S_LOAD = 2'd0,
        S_FULL = 2'd1,
        S_READ = 2'd2
    } state_t;

    localparam logic [AW-1:0] LAST_PTR = AW'(NUM_ROWS - 1);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [AW-1:0]          r_wr_ptr;
    logic [AW-1:0]          r_rd_ptr;
    logic [KW-1:0]          r_k_lat;
    logic                   r_err_k;
    logic [7:0]             r_pass_count;
    logic [RW-1:0]          r_mem_row [NUM_ROWS];
    logic [SUM_WIDTH-1:0]   r_mem_sum [NUM_ROWS];

    logic                   w_wr_fire;
    logic                   w_rd_fire;
    logic                   w_k_ok;
    logic                   w_start_ok;
    logic [RW-1:0]          w_masked_row;

    assign w_wr_fire  = (r_state == S_LOAD) && i_wr_valid;
    assign w_rd_fire  = (r_state == S_READ) && i_rd_ready;
    assign w_k_ok     = (i_k_cols != '0) && (i_k_cols <= KW'(MAX_COLS));
    assign w_start_ok = (r_state == S_FULL) && i_rd_start && w_k_ok;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_LOAD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_LOAD: if (w_wr_fire && (r_wr_ptr == LAST_PTR)) w_state_nxt = S_FULL;
            S_FULL: if (w_start_ok) w_state_nxt = S_READ;
            S_READ: if (w_rd_fire && (r_rd_ptr == LAST_PTR)) w_state_nxt = S_FULL;
            default: w_state_nxt = S_LOAD;
        endcase
        if (i_clear) w_state_nxt = S_LOAD;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_k_lat      <= '0;
            r_err_k      <= 1'b0;
            r_pass_count <= 8'd0;
        end else begin
            if (w_wr_fire) begin
                r_wr_ptr <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + AW'(1);
            end
            if ((r_state == S_FULL) && i_rd_start) begin
                if (w_k_ok) begin
                    r_k_lat  <= i_k_cols;
                    r_rd_ptr <= '0;
                end else begin
                    r_err_k  <= 1'b1;
                end
            end
            if (w_rd_fire) begin
                if (r_rd_ptr == LAST_PTR) begin
                    r_rd_ptr     <= '0;
                    r_pass_count <= r_pass_count + 8'd1;
                end else begin
                    r_rd_ptr     <= r_rd_ptr + AW'(1);
                end
            end
        end
    end

    // Storage has no reset so clear can keep the key bits while still forcing a reload.
    always_ff @(posedge i_clk) begin
        if (w_wr_fire && !i_rst && !i_clear) begin
            r_mem_row[r_wr_ptr] <= i_wr_row;
            r_mem_sum[r_wr_ptr] <= i_wr_sum;
        end
    end

    always_comb begin
        w_masked_row = '0;
        for (int c = 0; c < MAX_COLS; c++) begin
            if (KW'(c) < r_k_lat) begin
                w_masked_row[c*DATA_WIDTH +: DATA_WIDTH] = r_mem_row[r_rd_ptr][c*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign o_wr_ready   = (r_state == S_LOAD);
    assign o_rd_valid   = (r_state == S_READ);
    assign o_rd_row     = o_rd_valid ? w_masked_row : '0;
    assign o_rd_sum     = o_rd_valid ? r_mem_sum[r_rd_ptr] : '0;
    assign o_rd_last    = o_rd_valid && (r_rd_ptr == LAST_PTR);
    assign o_cache_full = (r_state != S_LOAD);
    assign o_err_k      = r_err_k;
    assign o_pass_count = r_pass_count;
    assign o_state      = r_state;

endmodule

// File: tb/tb_public_key_row_cache.sv
// Directed bench for public_key_row_cache: load, masked reads, stalls, illegal k,
// clear mid-read, and ignored starts/writes.
module tb_public_key_row_cache;

    localparam int DW = 16;
    localparam int NR = 8;
    localparam int MC = 4;
    localparam int SW = 16;
    localparam int KW = 3;
    localparam int RW = MC * DW;

    localparam logic [1:0] ST_LOAD = 2'd0;
    localparam logic [1:0] ST_FULL = 2'd1;
    localparam logic [1:0] ST_READ = 2'd2;

    logic          clk = 1'b0;
    logic          rst;
    logic          clear;
    logic [KW-1:0] k_cols;
    logic          wr_valid;
    logic          wr_ready;
    logic [RW-1:0] wr_row;
    logic [SW-1:0] wr_sum;
    logic          rd_start;
    logic          rd_valid;
    logic          rd_ready;
    logic [RW-1:0] rd_row;
    logic [SW-1:0] rd_sum;
    logic          rd_last;
    logic          cache_full;
    logic          err_k;
    logic [7:0]    pass_count;
    logic [1:0]    state;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [RW-1:0] row;
        logic [SW-1:0] sum;
        logic          last;
    } vec_t;

    vec_t tbl [NR];

    public_key_row_cache #(
        .DATA_WIDTH(DW), .NUM_ROWS(NR), .MAX_COLS(MC), .SUM_WIDTH(SW)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_clear(clear), .i_k_cols(k_cols),
        .i_wr_valid(wr_valid), .o_wr_ready(wr_ready), .i_wr_row(wr_row), .i_wr_sum(wr_sum),
        .i_rd_start(rd_start), .o_rd_valid(rd_valid), .i_rd_ready(rd_ready),
        .o_rd_row(rd_row), .o_rd_sum(rd_sum), .o_rd_last(rd_last),
        .o_cache_full(cache_full), .o_err_k(err_k), .o_pass_count(pass_count), .o_state(state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [RW-1:0] key_row(input int i);
        logic [RW-1:0] r;
        r = '0;
        for (int c = 0; c < MC; c++) r[c*DW +: DW] = 16'(i * 16 + c);
        return r;
    endfunction

    function automatic logic [RW-1:0] exp_row(input int i, input int k);
        logic [RW-1:0] r;
        r = '0;
        for (int c = 0; c < k; c++) r[c*DW +: DW] = 16'(i * 16 + c);
        return r;
    endfunction

    task automatic load_rows(input int sum_base);
        for (int i = 0; i < NR; i++) begin
            check("load_wr_ready", wr_ready, 1);
            wr_valid = 1'b1;
            wr_row   = key_row(i);
            wr_sum   = 16'(sum_base + i);
            tick();
        end
        wr_valid = 1'b0;
        check("load_done_full", cache_full, 1);
        check("load_done_wr_ready", wr_ready, 0);
    endtask

    // Full pass with rd_ready high; garbage writes are offered throughout.
    task automatic read_pass(input int k, input int sum_base);
        rd_start = 1'b1;
        k_cols   = KW'(k);
        wr_valid = 1'b1;
        wr_row   = {RW{1'b1}};
        wr_sum   = 16'hFFFF;
        rd_ready = 1'b1;
        tick();
        rd_start = 1'b0;
        for (int i = 0; i < NR; i++) begin
            check("pass_valid", rd_valid, 1);
            check("pass_row", rd_row, exp_row(i, k));
            check("pass_sum", rd_sum, 16'(sum_base + i));
            check("pass_last", rd_last, (i == NR - 1) ? 1 : 0);
            tick();
        end
        wr_valid = 1'b0;
        check("pass_end_valid", rd_valid, 0);
        check("pass_end_state", state, ST_FULL);
    endtask

    initial begin
        tbl[0] = '{64'h0000_0002_0001_0000, 16'd0, 1'b0};
        tbl[1] = '{64'h0000_0012_0011_0010, 16'd1, 1'b0};
        tbl[2] = '{64'h0000_0022_0021_0020, 16'd2, 1'b0};
        tbl[3] = '{64'h0000_0032_0031_0030, 16'd3, 1'b0};
        tbl[4] = '{64'h0000_0042_0041_0040, 16'd4, 1'b0};
        tbl[5] = '{64'h0000_0052_0051_0050, 16'd5, 1'b0};
        tbl[6] = '{64'h0000_0062_0061_0060, 16'd6, 1'b0};
        tbl[7] = '{64'h0000_0072_0071_0070, 16'd7, 1'b1};

        rst = 1'b1; clear = 1'b0; k_cols = '0; wr_valid = 1'b0; wr_row = '0; wr_sum = '0;
        rd_start = 1'b0; rd_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        check("rst_rd_valid", rd_valid, 0);
        check("rst_rd_last", rd_last, 0);
        check("rst_rd_row", rd_row, 0);
        check("rst_rd_sum", rd_sum, 0);
        check("rst_wr_ready", wr_ready, 1);
        check("rst_cache_full", cache_full, 0);
        check("rst_err_k", err_k, 0);
        check("rst_pass_count", pass_count, 0);
        check("rst_state", state, ST_LOAD);

        // Load with rd_start pulses in LOAD, including on the final write.
        for (int i = 0; i < NR; i++) begin
            check("t1_wr_ready", wr_ready, 1);
            check("t1_cache_full", cache_full, 0);
            check("t1_rd_valid", rd_valid, 0);
            wr_valid = 1'b1;
            wr_row   = key_row(i);
            wr_sum   = 16'(i);
            rd_start = (i == 2 || i == 7);
            k_cols   = 3'd3;
            tick();
        end
        rd_start = 1'b0;
        check("t1_wr_ready_drop", wr_ready, 0);
        check("t1_cache_full", cache_full, 1);
        check("t1_no_start", rd_valid, 0);
        check("t1_state", state, ST_FULL);
        // wr_valid still high with garbage: dropped in FULL.
        wr_row = {RW{1'b1}};
        wr_sum = 16'hFFFF;
        tick(); tick();
        check("t6_full_state", state, ST_FULL);

        // Pass at k=3; k_cols changes and rd_start repeats during READ are ignored.
        rd_start = 1'b1;
        k_cols   = 3'd3;
        rd_ready = 1'b1;
        tick();
        for (int i = 0; i < NR; i++) begin
            check("t2_valid", rd_valid, 1);
            check("t2_row", rd_row, tbl[i].row);
            check("t2_sum", rd_sum, tbl[i].sum);
            check("t2_last", rd_last, tbl[i].last);
            rd_start = 1'b1;
            k_cols   = 3'd1;
            tick();
        end
        check("t2_end_valid", rd_valid, 0);
        check("t2_pass_count", pass_count, 1);
        check("t2_state", state, ST_FULL);
        rd_start = 1'b0;
        wr_valid = 1'b0;

        // Replay at k=4 with rd_ready toggling 1,0,1,0.
        begin
            int ptr;
            int cyc;
            ptr = 0;
            cyc = 0;
            rd_start = 1'b1;
            k_cols   = 3'd4;
            tick();
            rd_start = 1'b0;
            while (ptr < NR && cyc < 40) begin
                check("t3_valid", rd_valid, 1);
                check("t3_row", rd_row, exp_row(ptr, 4));
                check("t3_sum", rd_sum, 16'(ptr));
                check("t3_last", rd_last, (ptr == NR - 1) ? 1 : 0);
                rd_ready = ((cyc % 2) == 0);
                tick();
                if ((cyc % 2) == 0) ptr++;
                cyc++;
            end
            check("t3_rows_done", 64'(ptr), 64'(NR));
            check("t3_cycles", 64'(cyc), 64'(2 * NR - 1));
            check("t3_end_valid", rd_valid, 0);
            check("t3_pass_count", pass_count, 2);
        end

        // Illegal k_cols in FULL.
        rd_ready = 1'b1;
        rd_start = 1'b1;
        k_cols   = 3'd0;
        tick();
        check("t4_err_k0", err_k, 1);
        check("t4_k0_valid", rd_valid, 0);
        check("t4_k0_state", state, ST_FULL);
        k_cols = 3'd5;
        tick();
        rd_start = 1'b0;
        check("t4_err_k5", err_k, 1);
        check("t4_k5_valid", rd_valid, 0);
        tick();
        check("t4_sticky", err_k, 1);
        check("t4_pass_hold", pass_count, 2);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("t4_clr_err", err_k, 0);
        check("t4_clr_full", cache_full, 0);
        check("t4_clr_wr_ready", wr_ready, 1);
        check("t4_clr_pass", pass_count, 0);
        check("t4_clr_state", state, ST_LOAD);

        // Clear after three read handshakes, then reload with new sums.
        load_rows(0);
        rd_start = 1'b1;
        k_cols   = 3'd2;
        rd_ready = 1'b1;
        tick();
        rd_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("t5_row", rd_row, exp_row(i, 2));
            tick();
        end
        check("t5_row3_valid", rd_valid, 1);
        check("t5_row3_sum", rd_sum, 3);
        rd_ready = 1'b0;
        clear    = 1'b1;
        tick();
        clear = 1'b0;
        check("t5_abort_valid", rd_valid, 0);
        check("t5_abort_state", state, ST_LOAD);
        check("t5_abort_pass", pass_count, 0);
        load_rows(100);
        read_pass(1, 100);
        check("t5_pass_count", pass_count, 1);

        // The garbage writes offered during that pass must not have landed.
        read_pass(4, 100);
        check("t6_pass_count", pass_count, 2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
